// File: rtl/vec_line_raster_if.sv
// Pixel handshake between the line rasteriser and the frame-buffer writer.
// The master presents a pixel on pix_we and holds it until pix_ready.
interface vec_line_raster_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [3:0] pix_i;
    logic       pix_we;
    logic       pix_ready;

    modport master (
        output pix_x, pix_y, pix_i, pix_we,
        input  pix_ready
    );

    modport slave (
        input  pix_x, pix_y, pix_i, pix_we,
        output pix_ready
    );
endinterface

// File: rtl/vec_line_raster.sv
// Segment FIFO plus Bresenham stepper feeding the frame-buffer writer.
// Define RASTER_CLIP_EN to suppress off-screen pixels instead of wrapping them.
module vec_line_raster #(
    parameter int FIFO_DEPTH  = 16,
    parameter int COORD_SHIFT = 3,
    parameter int SCR_W       = 640,
    parameter int SCR_H       = 480
) (
    input  logic              clk_in,
    input  logic              rst_b,
    input  logic [12:0]       startX,
    input  logic [12:0]       startY,
    input  logic [12:0]       endX,
    input  logic [12:0]       endY,
    input  logic [3:0]        intensity,
    input  logic              lrWrite,
    vec_line_raster_if.master pix,
    output logic              busy,
    output logic              ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;
    state_t state, stateNext;

    logic [55:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     rdPtr, wrPtr;
    logic [AW:0]       count;
    logic [55:0]       seg;
    logic              doPop, doPush;

    logic signed [13:0] curX, curY, endPX, endPY;
    logic [13:0]        dx, dy;
    logic               negX, negY;
    logic signed [15:0] err;
    logic [9:0]         pixX, pixY;
    logic [3:0]         pixI;
    logic               pixWe;

    logic signed [13:0] p0x, p0y, p1x, p1y;
    logic [13:0]        dxL, dyL;
    logic signed [15:0] errL, errStep;
    logic signed [16:0] e2;
    logic               xMove, yMove;
    logic signed [13:0] nextX, nextY;
    logic               emitP0, emitNext;
    logic               advance, atEnd;

    function automatic logic signed [13:0] mapX(input logic [12:0] v);
        logic signed [13:0] e;
        e = $signed({v[12], v});
        return (e >>> COORD_SHIFT) + 14'(SCR_W / 2);
    endfunction

    function automatic logic signed [13:0] mapY(input logic [12:0] v);
        logic signed [13:0] e;
        e = $signed({v[12], v});
        return 14'(SCR_H / 2) - (e >>> COORD_SHIFT);
    endfunction

`ifdef RASTER_CLIP_EN
    function automatic logic onScr(input logic signed [13:0] x,
                                   input logic signed [13:0] y);
        return (x >= 0) && (x < 14'(SCR_W)) &&
               (y >= 0) && (y < 14'(SCR_H));
    endfunction
`endif

    assign doPush = lrWrite && ((count != FULL_CNT) || doPop);
    assign busy   = (state != IDLE) || (count != '0);
    assign advance = !pixWe || pix.pix_ready;
    assign atEnd   = (curX == endPX) && (curY == endPY);

    assign pix.pix_x  = pixX;
    assign pix.pix_y  = pixY;
    assign pix.pix_i  = pixI;
    assign pix.pix_we = pixWe;

    // Segment storage; reads are gated by count so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (doPush) mem[wrPtr] <= {startX, startY, endX, endY, intensity};
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk_in) begin
        if (!rst_b) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (lrWrite && !doPush) ovf <= 1'b1;
        end
    end

    // Endpoint mapping and Bresenham setup/step arithmetic.
    always_comb begin
        p0x  = mapX(seg[55:43]);
        p0y  = mapY(seg[42:30]);
        p1x  = mapX(seg[29:17]);
        p1y  = mapY(seg[16:4]);
        dxL  = (p1x >= p0x) ? 14'(p1x - p0x) : 14'(p0x - p1x);
        dyL  = (p1y >= p0y) ? 14'(p1y - p0y) : 14'(p0y - p1y);
        errL = $signed({2'b0, dxL}) - $signed({2'b0, dyL});
        e2    = {err, 1'b0};
        xMove = e2 > -$signed({3'b0, dy});
        yMove = e2 < $signed({3'b0, dx});
        errStep = err;
        if (xMove) errStep = errStep - $signed({2'b0, dy});
        if (yMove) errStep = errStep + $signed({2'b0, dx});
        nextX = curX;
        nextY = curY;
        if (xMove) nextX = negX ? curX - 14'sd1 : curX + 14'sd1;
        if (yMove) nextY = negY ? curY - 14'sd1 : curY + 14'sd1;
`ifdef RASTER_CLIP_EN
        emitP0   = onScr(p0x, p0y);
        emitNext = onScr(nextX, nextY);
`else
        emitP0   = 1'b1;
        emitNext = 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_b) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic and FIFO pop decision.
    always_comb begin
        stateNext = state;
        doPop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    doPop     = 1'b1;
                    stateNext = LOAD;
                end
            end
            LOAD: stateNext = (seg[3:0] == 4'd0) ? IDLE : DRAW;
            DRAW: if (advance && atEnd) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Working registers and the registered pixel output.
    always_ff @(posedge clk_in) begin
        if (!rst_b) begin
            seg   <= '0;
            curX  <= '0;
            curY  <= '0;
            endPX <= '0;
            endPY <= '0;
            dx    <= '0;
            dy    <= '0;
            negX  <= 1'b0;
            negY  <= 1'b0;
            err   <= '0;
            pixX  <= '0;
            pixY  <= '0;
            pixI  <= '0;
            pixWe <= 1'b0;
        end else begin
            if (doPop) seg <= mem[rdPtr];
            if (state == LOAD) begin
                curX  <= p0x;
                curY  <= p0y;
                endPX <= p1x;
                endPY <= p1y;
                dx    <= dxL;
                dy    <= dyL;
                negX  <= p1x < p0x;
                negY  <= p1y < p0y;
                err   <= errL;
                pixX  <= p0x[9:0];
                pixY  <= p0y[9:0];
                pixI  <= seg[3:0];
                pixWe <= (seg[3:0] != 4'd0) && emitP0;
            end else if (state == DRAW && advance) begin
                if (atEnd) begin
                    pixWe <= 1'b0;
                end else begin
                    curX  <= nextX;
                    curY  <= nextY;
                    err   <= errStep;
                    pixX  <= nextX[9:0];
                    pixY  <= nextY[9:0];
                    pixWe <= emitNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_line_raster.sv
// Directed bench for vec_line_raster: line shapes, backpressure,
// clipping, FIFO overflow, zero-intensity/zero-length and reset abort.
module tb_vec_line_raster;
    logic        clk_in = 1'b0;
    logic        rst_b;
    logic [12:0] startX, startY, endX, endY;
    logic [3:0]  intensity;
    logic        lrWrite;
    logic        busy, ovf;

    vec_line_raster_if pix();

    vec_line_raster dut (
        .clk_in    (clk_in),
        .rst_b     (rst_b),
        .startX    (startX),
        .startY    (startY),
        .endX      (endX),
        .endY      (endY),
        .intensity (intensity),
        .lrWrite   (lrWrite),
        .pix       (pix.master),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk_in = ~clk_in;

    int nChecks = 0;
    int nFails  = 0;
    logic [23:0] pixQ[$];
    int diagX [11] = '{320, 320, 319, 319, 318, 318, 317, 317, 316, 316, 315};

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int px(input int x, input int y, input int i);
        logic [23:0] v;
        v = {x[9:0], y[9:0], i[3:0]};
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sendSeg(input logic [12:0] sx, input logic [12:0] sy,
                           input logic [12:0] ex, input logic [12:0] ey,
                           input logic [3:0] it);
        startX    = sx;
        startY    = sy;
        endX      = ex;
        endY      = ey;
        intensity = it;
        lrWrite   = 1'b1;
        tick();
        lrWrite   = 1'b0;
    endtask

    // Samples start right after the strobe edge (j = 0).
    task automatic runSeg(input int maxCyc, input bit toggle,
                          output int busyCnt, output int firstWe,
                          output int holdErr);
        logic       pend;
        logic [9:0] hx, hy;
        int         j;
        busyCnt = 0;
        firstWe = -1;
        holdErr = 0;
        pend    = 1'b0;
        hx      = '0;
        hy      = '0;
        j       = 0;
        while (j < maxCyc) begin
            if (pend && (!pix.pix_we || pix.pix_x !== hx || pix.pix_y !== hy))
                holdErr++;
            if (!busy) break;
            busyCnt++;
            pix.pix_ready = toggle ? (j % 2 == 1) : 1'b1;
            if (pix.pix_we && firstWe < 0) firstWe = j;
            if (pix.pix_we && pix.pix_ready)
                pixQ.push_back({pix.pix_x, pix.pix_y, pix.pix_i});
            pend = pix.pix_we && !pix.pix_ready;
            hx   = pix.pix_x;
            hy   = pix.pix_y;
            tick();
            j++;
        end
        check("run_idle", 32'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, fw, he, n5, nClip;
        rst_b         = 1'b0;
        lrWrite       = 1'b0;
        startX        = '0;
        startY        = '0;
        endX          = '0;
        endY          = '0;
        intensity     = '0;
        pix.pix_ready = 1'b1;
        repeat (3) tick();

        check("rst_we",   32'(pix.pix_we), 0);
        check("rst_x",    32'(pix.pix_x), 0);
        check("rst_y",    32'(pix.pix_y), 0);
        check("rst_i",    32'(pix.pix_i), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf",  32'(ovf), 0);
        rst_b = 1'b1;
        tick();

        pixQ.delete();
        sendSeg(13'd0, 13'd0, 13'd80, 13'd0, 4'd7);
        runSeg(200, 1'b0, bc, fw, he);
        check("h_count", pixQ.size(), 11);
        check("h_first", fw, 2);
        check("h_busy", bc, 13);
        for (int k = 0; k < pixQ.size() && k < 11; k++)
            check("h_pix", 32'(pixQ[k]), px(320 + k, 240, 7));

        pixQ.delete();
        sendSeg(13'd0, 13'd0, -13'sd40, -13'sd80, 4'd2);
        runSeg(200, 1'b0, bc, fw, he);
        check("d_count", pixQ.size(), 11);
        check("d_busy", bc, 13);
        for (int k = 0; k < pixQ.size() && k < 11; k++)
            check("d_pix", 32'(pixQ[k]), px(diagX[k], 240 + k, 2));

        pixQ.delete();
        sendSeg(13'd0, 13'd0, 13'd80, 13'd0, 4'd7);
        runSeg(400, 1'b1, bc, fw, he);
        check("bp_count", pixQ.size(), 11);
        check("bp_hold", he, 0);
        for (int k = 0; k < pixQ.size() && k < 11; k++)
            check("bp_pix", 32'(pixQ[k]), px(320 + k, 240, 7));

`ifdef RASTER_CLIP_EN
        nClip = 20;
`else
        nClip = 31;
`endif
        pixQ.delete();
        sendSeg(13'd2400, 13'd0, 13'd2640, 13'd0, 4'd4);
        runSeg(400, 1'b0, bc, fw, he);
        check("c_count", pixQ.size(), nClip);
        check("c_busy", bc, 33);
        for (int k = 0; k < pixQ.size() && k < nClip; k++)
            check("c_pix", 32'(pixQ[k]), px(620 + k, 240, 4));

        pixQ.delete();
        pix.pix_ready = 1'b0;
        sendSeg(13'd8, 13'd8, 13'd8, 13'd8, 4'd3);
        for (int k = 0; k < 10 && !pix.pix_we; k++) tick();
        check("o_stall_we", 32'(pix.pix_we), 1);
        for (int k = 0; k < 17; k++) begin
            sendSeg(13'd0, 13'd0, 13'd0, 13'd0, 4'd5);
            if (k == 15) check("o_ovf16", 32'(ovf), 0);
        end
        check("o_ovf17", 32'(ovf), 1);
        check("o_busy", 32'(busy), 1);
        runSeg(400, 1'b0, bc, fw, he);
        check("o_total", pixQ.size(), 17);
        n5 = 0;
        foreach (pixQ[k]) if (pixQ[k] == 24'(px(320, 240, 5))) n5++;
        check("o_drawn", n5, 16);
        if (pixQ.size() > 0)
            check("z_len_pix", 32'(pixQ[0]), px(321, 239, 3));

        pixQ.delete();
        sendSeg(13'd0, 13'd0, 13'd80, 13'd0, 4'd0);
        runSeg(100, 1'b0, bc, fw, he);
        check("zi_count", pixQ.size(), 0);
        check("zi_busy", bc, 2);

        pixQ.delete();
        pix.pix_ready = 1'b1;
        sendSeg(13'd0, 13'd0, 13'd80, 13'd0, 4'd7);
        sendSeg(13'd0, 13'd0, 13'd0, 13'd80, 4'd6);
        repeat (3) tick();
        check("r_pre_we", 32'(pix.pix_we), 1);
        rst_b = 1'b0;
        tick();
        check("r_we",   32'(pix.pix_we), 0);
        check("r_busy", 32'(busy), 0);
        check("r_ovf",  32'(ovf), 0);
        rst_b = 1'b1;
        repeat (3) tick();
        check("r_fifo", 32'(busy), 0);
        check("r_we2",  32'(pix.pix_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/vec_line_raster.md
# vec_line_raster

Raster back-end for the vector generator. It captures each drawn segment (start/end point and intensity, strobed by `lrWrite`) into a small FIFO. It converts vector-space coordinates to screen pixels and walks each segment with a Bresenham stepper. Each pixel is emitted to the frame-buffer writer over a valid/ready handshake. It sits directly downstream of the vector-generator core and upstream of the frame-buffer arbiter.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: segment FIFO entries; power of two, minimum 2.
- `COORD_SHIFT`, 3: arithmetic right shift from vector space to pixels.
- `SCR_W`, 640: screen width in pixels; at most 1024.
- `SCR_H`, 480: screen height in pixels; at most 1024.

Ports (one clock; reset is synchronous and active-low):
- `clk_in` in 1: clock. Every register updates on its rising edge.
- `rst_b` in 1: synchronous active-low reset.
- `startX`, `startY`, `endX`, `endY` in 13 each: signed two's-complement vector coordinates.
- `intensity` in 4: segment intensity.
- `lrWrite` in 1: one-cycle strobe; push the current segment.
- `pix_x` out 10, `pix_y` out 10: pixel coordinate.
- `pix_i` out 4: pixel intensity.
- `pix_we` out 1: pixel valid.
- `pix_ready` in 1: frame-buffer accepts the pixel.
- `busy` out 1: FIFO non-empty or a segment is in progress.
- `ovf` out 1: sticky flag; a segment was dropped.

## Operation
Segment FIFO:
- Entry layout is {startX, startY, endX, endY, intensity}, 56 bits.
- Push on `lrWrite`. The push is accepted when count < `FIFO_DEPTH`, or when a pop occurs in the same cycle.
- Otherwise the segment is dropped and `ovf` is set. `ovf` is cleared only by reset.

Coordinate mapping, computed in 14-bit signed:
- px = (x >>> COORD_SHIFT) + SCR_W/2.
- py = SCR_H/2 − (y >>> COORD_SHIFT). The Y axis is flipped.

State machine:
- IDLE: if the FIFO is non-empty, pop the head into working registers and go to LOAD.
- LOAD:
  - Map both endpoints to pixels.
  - Compute dx = |px1−px0| and dy = |py1−py0| (14-bit unsigned).
  - Compute sx, sy = ±1 and err = dx − dy (16-bit signed).
  - Set cur = p0.
  - If intensity == 0, go to IDLE with no pixels emitted. Otherwise go to DRAW.
- DRAW: present cur.
  - Emit condition: cur is on-screen (0 ≤ px < SCR_W and 0 ≤ py < SCR_H), or clipping is compiled out. When it holds, `pix_we`=1 and the pixel is held stable until `pix_ready`=1.
  - Advance when the pixel is accepted, or in one cycle when the pixel is suppressed.
  - If cur == p1, go to IDLE instead of advancing.
  - Advance step: e2 = 2·err. If e2 > −dy, then err −= dy and x += sx. If e2 < dx, then err += dx and y += sy. Both updates use the old err.
- A zero-length segment emits exactly one pixel.
- An accepted segment emits max(dx,dy)+1 pixels (before clipping), in order from p0 to p1.
- `pix_i` = the segment intensity for every pixel of the segment.
- `busy` = (state ≠ IDLE) or (FIFO count ≠ 0).

## Timing
- Reset values: `pix_we`=0, `pix_x`=0, `pix_y`=0, `pix_i`=0, `busy`=0, `ovf`=0, FIFO empty, state IDLE.
- Reset asserted mid-segment aborts the segment: `pix_we` is low from the next edge and FIFO contents are discarded.
- Latency with an empty FIFO and IDLE state, `lrWrite` sampled at edge N:
  - Entry is written at N.
  - Entry is popped at N+1 (state LOAD).
  - `pix_we` is high after N+2 with pixel p0.
- Throughput is one pixel per cycle while `pix_ready`=1. Each suppressed (clipped) pixel costs one cycle.
- After the last pixel is accepted, the FSM is in IDLE at the next edge. A queued segment pops one edge later.
- `pix_we` never deasserts without acceptance, except on reset.
- `pix_x`, `pix_y` and `pix_i` are registered outputs.
- `pix_x`/`pix_y` output the low 10 bits of the internal coordinate.

## Configuration
- `RASTER_CLIP_EN` defined:
  - Off-screen pixels are stepped through but never asserted on `pix_we`.
  - Every emitted pixel satisfies 0 ≤ `pix_x` < SCR_W and 0 ≤ `pix_y` < SCR_H.
- `RASTER_CLIP_EN` undefined:
  - Every stepped pixel is emitted.
  - `pix_x`/`pix_y` are the 10-bit truncation of the internal coordinate, so off-screen pixels wrap.

## Test plan
Defaults for every case: SCR 640×480, COORD_SHIFT 3, clip enabled, `pix_ready` tied 1 unless stated.
- Horizontal segment (0,0)→(80,0), intensity 7, `lrWrite` at edge N:
  - 11 pixels, x = 320..330, y = 240, `pix_i`=7.
  - First `pix_we` after N+2.
  - `busy` falls after the last pixel.
- Diagonal segment (0,0)→(−40,−80):
  - 11 pixels from (320,240) to (315,250).
  - Bresenham sequence matches the reference model.
  - y steps every pixel.
- Backpressure: same horizontal segment with `pix_ready` toggling 1/0 each cycle:
  - `pix_x`/`pix_y` are held while not ready.
  - 11 accepted pixels, no duplicates or skips.
- Clip: segment (2400,0)→(2640,0) (px 620..650):
  - Exactly 20 pixels emitted (x 620..639).
  - Total DRAW time 31 cycles.
- Overflow: 17 back-to-back `lrWrite` while `pix_ready`=0 (FIFO_DEPTH 16):
  - `ovf` set on the strobe that is dropped.
  - Exactly 16 segments are drawn after release.
- Zero intensity, zero length, and reset:
  - Zero-intensity segment: no pixels.
  - Zero-length segment at (8,8): pixel (321,239).
  - `rst_b` low mid-segment: `pix_we`=0 next edge, `busy`=0.
